// File: rtl/oled_spi_batch_sched.sv
// OLED SPI batch scheduler: panel power-up sequencing, then arbitration of
// command/pixel batches into the MOSI byte buffer. Define OLED_SEQ_RR_EN for round-robin.
module oled_spi_batch_sched #(
    parameter int WIDTH        = 8,
    parameter int N            = 8,
    parameter int RES_CYCLES   = 1000,
    parameter int PWR_CYCLES   = 100000,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                 i_SCK,
    input  logic                 i_RST_N,
    input  logic                 i_CMD_REQ,
    input  logic [WIDTH*N-1:0]   i_CMD_DATA,
    input  logic [N-1:0]         i_CMD_DC,
    input  logic [4:0]           i_CMD_N,
    output logic                 o_CMD_ACK,
    input  logic                 i_PIX_REQ,
    input  logic [WIDTH*N-1:0]   i_PIX_DATA,
    input  logic [N-1:0]         i_PIX_DC,
    input  logic [4:0]           i_PIX_N,
    output logic                 o_PIX_ACK,
    output logic [WIDTH*N-1:0]   o_BUF_DATA,
    output logic [N-1:0]         o_BUF_DC,
    output logic [4:0]           o_BUF_N,
    output logic                 o_BUF_START,
    input  logic                 i_BUF_BUSY,
    output logic                 o_OLED_RES_N,
    output logic                 o_READY,
    output logic                 o_ERR
);

    localparam int PMAX = (RES_CYCLES > PWR_CYCLES) ? RES_CYCLES : PWR_CYCLES;
    localparam int PCW  = $clog2(PMAX + 1);

    localparam logic [2:0] S_RES_HOLD  = 3'd0;
    localparam logic [2:0] S_PWR_WAIT  = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_LAUNCH    = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_ACK       = 3'd6;

    logic [2:0]         r_state;
    logic [PCW-1:0]     r_pwr_cnt;
    logic [3:0]         r_to_cnt;
    logic               r_res_n;
    logic               r_ready;
    logic               r_err;
    logic               r_win_pix;
    logic [WIDTH*N-1:0] r_buf_data;
    logic [N-1:0]       r_buf_dc;
    logic [4:0]         r_buf_n;

    logic               w_any;
    logic               w_grant_pix;
    logic [4:0]         w_sel_n;
    logic [4:0]         w_clamp_n;

    assign w_any = i_CMD_REQ | i_PIX_REQ;

`ifdef OLED_SEQ_RR_EN
    logic r_last_pix;

    // On a tie, PIX wins only if CMD was granted last.
    assign w_grant_pix = i_PIX_REQ & (~i_CMD_REQ | ~r_last_pix);

    always_ff @(posedge i_SCK or negedge i_RST_N) begin
        if (!i_RST_N)
            r_last_pix <= 1'b1;
        else if (r_state == S_IDLE && w_any)
            r_last_pix <= w_grant_pix;
    end
`else
    assign w_grant_pix = i_PIX_REQ & ~i_CMD_REQ;
`endif

    assign w_sel_n   = w_grant_pix ? i_PIX_N : i_CMD_N;
    assign w_clamp_n = (w_sel_n > 5'(N)) ? 5'(N) : w_sel_n;

    always_ff @(posedge i_SCK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            r_state    <= S_RES_HOLD;
            r_pwr_cnt  <= '0;
            r_to_cnt   <= '0;
            r_res_n    <= 1'b0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_win_pix  <= 1'b0;
            r_buf_data <= '0;
            r_buf_dc   <= '0;
            r_buf_n    <= '0;
        end else begin
            case (r_state)
                S_RES_HOLD: begin
                    if (r_pwr_cnt == PCW'(RES_CYCLES - 1)) begin
                        r_pwr_cnt <= '0;
                        r_res_n   <= 1'b1;
                        r_state   <= S_PWR_WAIT;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + PCW'(1);
                    end
                end
                S_PWR_WAIT: begin
                    if (r_pwr_cnt == PCW'(PWR_CYCLES - 1)) begin
                        r_pwr_cnt <= '0;
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + PCW'(1);
                    end
                end
                S_IDLE: begin
                    if (w_any) begin
                        r_win_pix  <= w_grant_pix;
                        r_buf_data <= w_grant_pix ? i_PIX_DATA : i_CMD_DATA;
                        r_buf_dc   <= w_grant_pix ? i_PIX_DC : i_CMD_DC;
                        r_buf_n    <= w_clamp_n;
                        // Empty batches never touch the buffer.
                        r_state    <= (w_sel_n == 5'd0) ? S_ACK : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!i_BUF_BUSY) begin
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (i_BUF_BUSY) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_to_cnt == 4'(BUSY_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_ACK;
                    end else begin
                        r_to_cnt <= r_to_cnt + 4'd1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_BUF_BUSY)
                        r_state <= S_ACK;
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_RES_HOLD;
            endcase
        end
    end

    // Start is held off while the buffer still reports bytes in flight.
    assign o_BUF_START  = (r_state == S_LAUNCH) & ~i_BUF_BUSY;
    assign o_CMD_ACK    = (r_state == S_ACK) & ~r_win_pix;
    assign o_PIX_ACK    = (r_state == S_ACK) &  r_win_pix;
    assign o_BUF_DATA   = r_buf_data;
    assign o_BUF_DC     = r_buf_dc;
    assign o_BUF_N      = r_buf_n;
    assign o_OLED_RES_N = r_res_n;
    assign o_READY      = r_ready;
    assign o_ERR        = r_err;

endmodule

// File: tb/tb_oled_spi_batch_sched.sv
// Scoreboard bench for oled_spi_batch_sched: requesters and a buffer model
// feed expected grants into queues that a negedge monitor checks.
module tb_oled_spi_batch_sched;

    localparam int W = 8, NB = 8, RESC = 4, PWRC = 8, TO = 15;

    typedef struct packed {
        logic        pix;
        logic [4:0]  n;
        logic [63:0] data;
        logic [7:0]  dc;
    } exp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  dc;
        logic [4:0]  n;
    } pay_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_req, pix_req, cmd_ack, pix_ack;
    logic [63:0] cmd_data, pix_data, buf_data;
    logic [7:0]  cmd_dc, pix_dc, buf_dc;
    logic [4:0]  cmd_n, pix_n, buf_n;
    logic        buf_start, buf_busy, res_n, ready, err;

    exp_t exp_start[$];
    logic exp_ack[$];
    pay_t cmd_q[$], pix_q[$];

    int checks = 0, failures = 0;
    int cyc = 0, start_cyc = 0, ack_cyc = 0, fall_cyc = 0, err_cyc = 0;
    int cmd_req_cyc = 0, pix_req_cyc = 0, num_starts = 0, busy_len = 0;
    logic flush = 1'b0;

    oled_spi_batch_sched #(.WIDTH(W), .N(NB), .RES_CYCLES(RESC), .PWR_CYCLES(PWRC), .BUSY_TIMEOUT(TO)) dut (
        .i_SCK(clk), .i_RST_N(rst_n),
        .i_CMD_REQ(cmd_req), .i_CMD_DATA(cmd_data), .i_CMD_DC(cmd_dc), .i_CMD_N(cmd_n), .o_CMD_ACK(cmd_ack),
        .i_PIX_REQ(pix_req), .i_PIX_DATA(pix_data), .i_PIX_DC(pix_dc), .i_PIX_N(pix_n), .o_PIX_ACK(pix_ack),
        .o_BUF_DATA(buf_data), .o_BUF_DC(buf_dc), .o_BUF_N(buf_n), .o_BUF_START(buf_start),
        .i_BUF_BUSY(buf_busy), .o_OLED_RES_N(res_n), .o_READY(ready), .o_ERR(err)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic exp_grant(input logic pix, input logic [63:0] d, input logic [7:0] dc, input logic [4:0] en);
        exp_t e;
        exp_ack.push_back(pix);
        if (en != 5'd0) begin
            e.pix = pix; e.n = en; e.data = d; e.dc = dc;
            exp_start.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_ack.size() != 0 || cmd_q.size() != 0 || pix_q.size() != 0 || cmd_req || pix_req) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("wait_idle_timeout", 64'(k), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic power_up(input int last);
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("pu_res_n", 64'(res_n), 64'(i >= RESC));
            chk("pu_ready", 64'(ready), 64'(i >= RESC + PWRC));
            chk("pu_no_start", 64'(buf_start), 64'(0));
        end
    endtask

    // Command requester: holds payload until ack, then loads the next one.
    initial begin : cmd_proc
        logic a;
        cmd_req = 0; cmd_data = '0; cmd_dc = '0; cmd_n = '0;
        forever begin
            @(negedge clk); a = cmd_ack;
            @(posedge clk); #1;
            if (flush) begin
                cmd_req = 0; cmd_q.delete();
            end else begin
                if (cmd_req && a) begin cmd_q.delete(0); cmd_req = 0; end
                if (!cmd_req && cmd_q.size() > 0) begin
                    cmd_data = cmd_q[0].data; cmd_dc = cmd_q[0].dc; cmd_n = cmd_q[0].n;
                    cmd_req = 1; cmd_req_cyc = cyc;
                end
            end
        end
    end

    initial begin : pix_proc
        logic a;
        pix_req = 0; pix_data = '0; pix_dc = '0; pix_n = '0;
        forever begin
            @(negedge clk); a = pix_ack;
            @(posedge clk); #1;
            if (flush) begin
                pix_req = 0; pix_q.delete();
            end else begin
                if (pix_req && a) begin pix_q.delete(0); pix_req = 0; end
                if (!pix_req && pix_q.size() > 0) begin
                    pix_data = pix_q[0].data; pix_dc = pix_q[0].dc; pix_n = pix_q[0].n;
                    pix_req = 1; pix_req_cyc = cyc;
                end
            end
        end
    end

    // Buffer model: busy for busy_len cycles after a start; 0 means never busy.
    initial begin : buf_proc
        logic st;
        int bcnt = 0;
        buf_busy = 0;
        forever begin
            @(negedge clk); st = buf_start;
            @(posedge clk); #1;
            if (!rst_n) bcnt = 0;
            else if (st && busy_len > 0) bcnt = busy_len;
            else if (bcnt > 0) bcnt--;
            buf_busy = (bcnt > 0);
        end
    end

    initial begin : monitor
        logic pb = 0, pe = 0;
        exp_t e;
        logic ep;
        forever begin
            @(negedge clk);
            if (buf_start) begin
                start_cyc = cyc; num_starts++;
                chk("start_while_busy", 64'(buf_busy), 64'(0));
                if (exp_start.size() == 0) chk("unexpected_start", 64'(1), 64'(0));
                else begin
                    e = exp_start.pop_front();
                    chk("buf_n", 64'(buf_n), 64'(e.n));
                    chk("buf_data", buf_data, e.data);
                    chk("buf_dc", 64'(buf_dc), 64'(e.dc));
                end
            end
            if (cmd_ack || pix_ack) begin
                ack_cyc = cyc;
                chk("ack_both", 64'(cmd_ack & pix_ack), 64'(0));
                if (exp_ack.size() == 0) chk("unexpected_ack", 64'(1), 64'(0));
                else begin
                    ep = exp_ack.pop_front();
                    chk("ack_who", 64'(pix_ack), 64'(ep));
                end
            end
            if (pb && !buf_busy) fall_cyc = cyc;
            pb = buf_busy;
            if (err && !pe) err_cyc = cyc;
            pe = err;
        end
    end

    initial begin : main
        int ns, rel;
        pay_t p;
        repeat (3) @(negedge clk);
        chk("rst_res_n", 64'(res_n), 64'(0));
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_buf_n", 64'(buf_n), 64'(0));
        chk("rst_buf_data", buf_data, 64'(0));
        chk("rst_start", 64'(buf_start), 64'(0));
        @(posedge clk); #1 rst_n = 1;
        power_up(14);

        // CMD batch of 3 bytes, buffer busy for 24 clocks.
        busy_len = 24;
        @(negedge clk);
        ns = num_starts;
        exp_grant(0, 64'h0000_0000_00AF_A18D, 8'h00, 5'd3);
        p.data = 64'h0000_0000_00AF_A18D; p.dc = 8'h00; p.n = 5'd3; cmd_q.push_back(p);
        wait_idle();
        chk("cmd_start_count", 64'(num_starts - ns), 64'(1));
        chk("cmd_start_lat", 64'(start_cyc - cmd_req_cyc), 64'(1));
        chk("cmd_busy_len", 64'(fall_cyc - start_cyc), 64'(25));
        chk("cmd_ack_lat", 64'(ack_cyc - fall_cyc), 64'(1));

        // Empty pixel batch: immediate ack, no start.
        ns = num_starts;
        exp_grant(1, 64'h0, 8'h0, 5'd0);
        p.data = 64'h55; p.dc = 8'h01; p.n = 5'd0; pix_q.push_back(p);
        wait_idle();
        chk("pix0_no_start", 64'(num_starts - ns), 64'(0));
        chk("pix0_ack_lat", 64'(ack_cyc - pix_req_cyc), 64'(1));

        // Oversize pixel batch clamps to 8.
        busy_len = 8;
        exp_grant(1, 64'h0123_4567_89AB_CDEF, 8'hFF, 5'd8);
        p.data = 64'h0123_4567_89AB_CDEF; p.dc = 8'hFF; p.n = 5'd20; pix_q.push_back(p);
        wait_idle();

        // Simultaneous requests, two from each side.
        busy_len = 3;
`ifdef OLED_SEQ_RR_EN
        exp_grant(0, 64'h1111, 8'h00, 5'd2);
        exp_grant(1, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 5'd8);
        exp_grant(0, 64'h2222, 8'h01, 5'd2);
        exp_grant(1, 64'hB0B0_B0B0_B0B0_B0B0, 8'hFF, 5'd8);
`else
        exp_grant(0, 64'h1111, 8'h00, 5'd2);
        exp_grant(0, 64'h2222, 8'h01, 5'd2);
        exp_grant(1, 64'hA0A0_A0A0_A0A0_A0A0, 8'hFF, 5'd8);
        exp_grant(1, 64'hB0B0_B0B0_B0B0_B0B0, 8'hFF, 5'd8);
`endif
        p.data = 64'h1111; p.dc = 8'h00; p.n = 5'd2; cmd_q.push_back(p);
        p.data = 64'h2222; p.dc = 8'h01; p.n = 5'd2; cmd_q.push_back(p);
        p.data = 64'hA0A0_A0A0_A0A0_A0A0; p.dc = 8'hFF; p.n = 5'd8; pix_q.push_back(p);
        p.data = 64'hB0B0_B0B0_B0B0_B0B0; p.dc = 8'hFF; p.n = 5'd8; pix_q.push_back(p);
        wait_idle();

        // Buffer never goes busy: timeout, sticky error, ack still issued.
        busy_len = 0;
        chk("err_before", 64'(err), 64'(0));
        exp_grant(0, 64'h77, 8'h03, 5'd2);
        p.data = 64'h77; p.dc = 8'h03; p.n = 5'd2; cmd_q.push_back(p);
        wait_idle();
        chk("to_ack_lat", 64'(ack_cyc - start_cyc), 64'(16));
        chk("to_err_lat", 64'(err_cyc - start_cyc), 64'(16));
        chk("err_set", 64'(err), 64'(1));
        busy_len = 5;
        exp_grant(0, 64'h99, 8'h01, 5'd1);
        p.data = 64'h99; p.dc = 8'h01; p.n = 5'd1; cmd_q.push_back(p);
        wait_idle();
        chk("err_sticky", 64'(err), 64'(1));
        chk("after_to_ack_lat", 64'(ack_cyc - fall_cyc), 64'(1));

        // Reset mid-batch while in WAIT_DONE.
        busy_len = 24;
        exp_grant(0, 64'hDEAD, 8'h0F, 5'd4);
        p.data = 64'hDEAD; p.dc = 8'h0F; p.n = 5'd4; cmd_q.push_back(p);
        begin
            int k = 0;
            while (!buf_busy && k < 100) begin @(negedge clk); k++; end
            if (k >= 100) chk("busy_wait_timeout", 64'(k), 64'(0));
        end
        repeat (5) @(negedge clk);
        rst_n = 0;
        exp_ack.delete();
        flush = 1;
        #1;
        chk("mid_rst_start", 64'(buf_start), 64'(0));
        chk("mid_rst_ready", 64'(ready), 64'(0));
        chk("mid_rst_res_n", 64'(res_n), 64'(0));
        chk("mid_rst_err", 64'(err), 64'(0));
        chk("mid_rst_ack", 64'(cmd_ack | pix_ack), 64'(0));
        repeat (3) @(negedge clk);
        flush = 0;
        exp_start.delete();
        busy_len = 4;
        exp_grant(1, 64'hC0FFEE, 8'h1F, 5'd5);
        p.data = 64'hC0FFEE; p.dc = 8'h1F; p.n = 5'd5; pix_q.push_back(p);
        @(posedge clk); #1 rst_n = 1;
        rel = cyc;
        power_up(RESC + PWRC);
        wait_idle();
        chk("pre_ready_grant", 64'(start_cyc - rel), 64'(RESC + PWRC + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
